// File: rtl/gray_to_bin_decoder_if.sv
// Handshake bundle for the Gray-to-binary decoder.
// slave is the decoder's view, master the producer/consumer side.
interface gray_to_bin_decoder_if #(
  parameter int WIDTH     = 4,
  parameter int ERR_CNT_W = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     g_in;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     b_out;
  logic                 step_err;
  logic                 dir_up;
  logic [ERR_CNT_W-1:0] err_cnt;
  logic                 resync;

  modport master (
    output in_valid,
    output g_in,
    output out_ready,
    output resync,
    input  in_ready,
    input  out_valid,
    input  b_out,
    input  step_err,
    input  dir_up,
    input  err_cnt
  );

  modport slave (
    input  in_valid,
    input  g_in,
    input  out_ready,
    input  resync,
    output in_ready,
    output out_valid,
    output b_out,
    output step_err,
    output dir_up,
    output err_cnt
  );
endinterface

// File: rtl/gray_to_bin_decoder.sv
// Registered Gray-to-binary decoder, 1-cycle latency, valid/ready.
// GRAY_STEP_CHECK_EN builds the single-bit-step checker.
module gray_to_bin_decoder #(
  parameter int WIDTH     = 4,
  parameter int ERR_CNT_W = 8
) (
  input logic               clk,
  input logic               rst,
  gray_to_bin_decoder_if.slave bus
);

  function automatic logic [WIDTH-1:0] g2b(
    input logic [WIDTH-1:0] g
  );
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic             out_valid_q;
  logic [WIDTH-1:0] b_out_q;
  logic             in_ready;
  logic             accept;

  assign in_ready = !out_valid_q || bus.out_ready;
  assign accept   = bus.in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      b_out_q     <= '0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      b_out_q     <= g2b(bus.g_in);
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.b_out     = b_out_q;

`ifdef GRAY_STEP_CHECK_EN
  typedef enum logic {
    IDLE,
    TRACK
  } chk_state_e;

  chk_state_e           state_q;
  chk_state_e           state_d;
  logic [WIDTH-1:0]     prev_g_q;
  logic [WIDTH-1:0]     prev_g_d;
  logic                 step_err_q;
  logic                 step_err_d;
  logic                 dir_up_q;
  logic                 dir_up_d;
  logic [ERR_CNT_W-1:0] err_cnt_q;
  logic [ERR_CNT_W-1:0] err_cnt_d;

  logic [WIDTH-1:0]     diff;
  logic [WIDTH-1:0]     b_new;
  logic [WIDTH-1:0]     b_prev;
  logic                 first;
  logic                 d_zero;
  logic                 d_one;
  logic                 d_multi;

  assign diff    = bus.g_in ^ prev_g_q;
  assign b_new   = g2b(bus.g_in);
  assign b_prev  = g2b(prev_g_q);
  assign first   = (state_q == IDLE) || bus.resync;
  assign d_zero  = (diff == '0);
  // one-hot test: clearing the lowest set bit leaves nothing
  assign d_one   = !d_zero &&
                   ((diff & (diff - WIDTH'(1))) == '0);
  assign d_multi = !d_zero && !d_one;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      prev_g_q   <= '0;
      step_err_q <= 1'b0;
      dir_up_q   <= 1'b1;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      prev_g_q   <= prev_g_d;
      step_err_q <= step_err_d;
      dir_up_q   <= dir_up_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (accept) begin
      state_d = TRACK;
    end else if (bus.resync) begin
      state_d = IDLE;
    end
  end

  always_comb begin
    prev_g_d   = prev_g_q;
    step_err_d = step_err_q;
    dir_up_d   = dir_up_q;
    err_cnt_d  = err_cnt_q;
    if (accept) begin
      prev_g_d = bus.g_in;
      if (first) begin
        step_err_d = 1'b0;
      end else begin
        unique case (1'b1)
          d_zero: step_err_d = 1'b0;
          d_one: begin
            step_err_d = 1'b0;
            dir_up_d   = (b_new == b_prev + WIDTH'(1));
          end
          d_multi: begin
            step_err_d = 1'b1;
            if (!(&err_cnt_q)) begin
              err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.step_err = step_err_q;
  assign bus.dir_up   = dir_up_q;
  assign bus.err_cnt  = err_cnt_q;
`else
  logic unused_resync;

  assign unused_resync = bus.resync;
  assign bus.step_err  = 1'b0;
  assign bus.dir_up    = 1'b1;
  assign bus.err_cnt   = '0;
`endif

endmodule

// File: tb/tb_gray_to_bin_decoder.sv
// Directed bench for gray_to_bin_decoder; status expectations
// follow whether GRAY_STEP_CHECK_EN is defined.
module tb_gray_to_bin_decoder;

`ifdef GRAY_STEP_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  gray_to_bin_decoder_if #(.WIDTH(4), .ERR_CNT_W(8)) bus ();

  gray_to_bin_decoder #(.WIDTH(4), .ERR_CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] e_err(input logic [31:0] v);
    return CHK ? v : 32'd0;
  endfunction

  function automatic logic [31:0] e_dir(input logic v);
    return CHK ? {31'd0, v} : 32'd1;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.g_in      = 4'b0000;
    bus.out_ready = 1'b1;
    bus.resync    = 1'b0;
    cyc();
    cyc();
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_b_out", bus.b_out, 0);
    check("rst_step_err", bus.step_err, 0);
    check("rst_dir_up", bus.dir_up, 1);
    check("rst_err_cnt", bus.err_cnt, 0);
    rst = 1'b0;
    #1;
    check("rst_in_ready", bus.in_ready, 1);

    // single words
    bus.in_valid = 1'b1;
    bus.g_in     = 4'b0110;
    cyc();
    check("t1_valid", bus.out_valid, 1);
    check("t1_b", bus.b_out, 4'b0100);
    check("t1_err", bus.step_err, 0);
    bus.g_in = 4'b1000;
    cyc();
    check("t1_b2", bus.b_out, 4'b1111);
    check("t1_err2", bus.step_err, e_err(1));
    check("t1_cnt2", bus.err_cnt, e_err(1));
    bus.in_valid = 1'b0;
    rst = 1'b1;
    #1;
    rst = 1'b0;

    // back-to-back stream
    bus.in_valid = 1'b1;
    bus.g_in     = 4'b0000;
    #1;
    check("t2_rdy0", bus.in_ready, 1);
    cyc();
    check("t2_b0", bus.b_out, 0);
    bus.g_in = 4'b0001;
    check("t2_rdy1", bus.in_ready, 1);
    cyc();
    check("t2_b1", bus.b_out, 1);
    check("t2_dir1", bus.dir_up, 1);
    bus.g_in = 4'b0011;
    check("t2_rdy2", bus.in_ready, 1);
    cyc();
    check("t2_b2", bus.b_out, 2);
    bus.g_in = 4'b0010;
    check("t2_rdy3", bus.in_ready, 1);
    cyc();
    check("t2_b3", bus.b_out, 3);
    check("t2_dir3", bus.dir_up, 1);
    check("t2_err3", bus.step_err, 0);

    // wrap both ways, first word via coincident resync
    bus.g_in   = 4'b1000;
    bus.resync = 1'b1;
    cyc();
    bus.resync = 1'b0;
    check("t3_b15", bus.b_out, 15);
    check("t3_err15", bus.step_err, 0);
    bus.g_in = 4'b0000;
    cyc();
    check("t3_b0", bus.b_out, 0);
    check("t3_dir_up", bus.dir_up, 1);
    check("t3_err0", bus.step_err, 0);
    bus.g_in = 4'b1000;
    cyc();
    check("t3_bmax", bus.b_out, 15);
    check("t3_dir_dn", bus.dir_up, e_dir(1'b0));
    check("t3_cnt", bus.err_cnt, 0);

    // illegal jumps and saturation
    bus.g_in   = 4'b0011;
    bus.resync = 1'b1;
    cyc();
    bus.resync = 1'b0;
    check("t4_b_first", bus.b_out, 2);
    check("t4_err_first", bus.step_err, 0);
    bus.g_in = 4'b0110;
    cyc();
    check("t4_b_jump", bus.b_out, 4);
    check("t4_err_jump", bus.step_err, e_err(1));
    check("t4_cnt1", bus.err_cnt, e_err(1));
    for (int i = 0; i < 299; i++) begin
      bus.g_in = (i % 2 == 0) ? 4'b0011 : 4'b0110;
      cyc();
    end
    check("t4_cnt_sat", bus.err_cnt, e_err(255));
    check("t4_err_last", bus.step_err, e_err(1));
    check("t4_dir_hold", bus.dir_up, e_dir(1'b0));
    bus.in_valid = 1'b0;
    bus.resync   = 1'b1;
    cyc();
    bus.resync = 1'b0;
    check("t4_drain", bus.out_valid, 0);
    bus.in_valid = 1'b1;
    bus.g_in     = 4'b1111;
    cyc();
    check("t4_b_resync", bus.b_out, 4'b1010);
    check("t4_err_resync", bus.step_err, 0);
    check("t4_cnt_kept", bus.err_cnt, e_err(255));

    // backpressure
    bus.out_ready = 1'b0;
    bus.g_in      = 4'b1110;
    for (int i = 0; i < 5; i++) begin
      cyc();
      check("t5_rdy_low", bus.in_ready, 0);
      check("t5_b_hold", bus.b_out, 4'b1010);
      check("t5_valid", bus.out_valid, 1);
      bus.g_in = (i % 2 == 0) ? 4'b0000 : 4'b1110;
    end
    bus.g_in      = 4'b1110;
    bus.out_ready = 1'b1;
    #1;
    check("t5_rdy_up", bus.in_ready, 1);
    cyc();
    check("t5_b_new", bus.b_out, 4'b1011);
    check("t5_err_new", bus.step_err, 0);
    check("t5_dir_new", bus.dir_up, 1);

    // async reset between edges
    bus.g_in = 4'b1111;
    cyc();
    check("t6_b_pre", bus.b_out, 4'b1010);
    check("t6_dir_pre", bus.dir_up, e_dir(1'b0));
    #2;
    bus.in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("t6_valid", bus.out_valid, 0);
    check("t6_b", bus.b_out, 0);
    check("t6_err", bus.step_err, 0);
    check("t6_cnt", bus.err_cnt, 0);
    check("t6_dir", bus.dir_up, 1);
    rst = 1'b0;
    bus.in_valid = 1'b1;
    bus.g_in     = 4'b0101;
    cyc();
    check("t6_b_post", bus.b_out, 4'b0110);
    check("t6_err_post", bus.step_err, 0);
    bus.in_valid = 1'b0;
    cyc();
    check("t6_idle", bus.out_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/gray_to_bin_decoder.md
Name: gray_to_bin_decoder

Overview:
- Registered, parameterised Gray-to-binary decoder. It is the receive-side counterpart of the team's binary-to-Gray encoder.
- Sits at the consumer end of Gray-coded counter/pointer links, such as synchronised FIFO pointers.
- Accepts Gray words on a valid/ready handshake and returns binary with 1-cycle latency.
- Optionally checks that consecutive accepted codes differ by at most one bit, reports the count direction, and counts violations.

Parameters:
- WIDTH, 4, width of the Gray input and binary output (legal range 2..32).
- ERR_CNT_W, 8, width of the saturating step-error counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  g_in is valid this cycle.
- in_ready  output  1  decoder can accept g_in this cycle.
- g_in  input  WIDTH  Gray-coded input word.
- out_valid  output  1  b_out and status outputs are valid.
- out_ready  input  1  downstream accepts b_out this cycle.
- b_out  output  WIDTH  decoded binary word.
- step_err  output  1  current output word violated the single-bit-step rule.
- dir_up  output  1  last legal step was an increment (1) or a decrement (0).
- err_cnt  output  ERR_CNT_W  saturating count of step errors.
- resync  input  1  synchronous pulse that forgets the previous code; the next accept is treated as first.

Behaviour:
- Reset (async, immediate): out_valid=0, b_out=0, step_err=0, dir_up=1, err_cnt=0, checker state=IDLE, prev_g=0. in_ready=1 while rst is deasserted and out_valid=0.
- Conversion: b[WIDTH-1]=g[WIDTH-1]; b[i]=b[i+1]^g[i] for i=WIDTH-2..0. Purely bitwise, no carries, all WIDTH bits.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - Accept happens when in_valid && in_ready.
  - On accept: b_out, step_err and dir_up load at the next edge, and out_valid=1.
  - If out_ready && !accept: out_valid clears to 0.
  - While out_valid && !out_ready: b_out, step_err and dir_up hold stable. in_ready=0 and g_in is ignored.
  - Full throughput: one word per cycle when out_ready is held high.
- Latency: exactly 1 clock from accept to out_valid.
- Checker FSM, states IDLE and TRACK:
  - IDLE + accept: store prev_g=g_in, step_err=0, dir_up unchanged, move to TRACK.
  - TRACK + accept: d = g_in ^ prev_g, then prev_g=g_in.
    - popcount(d)==0 (hold): step_err=0, dir_up unchanged.
    - popcount(d)==1: step_err=0. dir_up=1 if b_new == (b_prev+1) mod 2^WIDTH, else 0.
    - popcount(d)>=2: step_err=1, dir_up unchanged, err_cnt += 1 saturating at all-ones.
  - Wrap-around is legal in both directions: binary max to 0 gives dir_up=1; 0 to max gives dir_up=0.
  - resync (any state): next state IDLE. err_cnt is not cleared.
  - resync coincident with an accept: the accepted word is treated as the first word, step_err=0, and the state becomes TRACK.
  - step_err is a per-word flag travelling with b_out, not a sticky bit.
- err_cnt updates on the same edge that loads the offending word.
- Reset mid-operation: any in-flight output is discarded immediately and the block returns to the reset values.

Optional Feature:
- Macro: GRAY_STEP_CHECK_EN.
- Defined: checker FSM, prev_g, step_err, dir_up and err_cnt are implemented as described above.
- Undefined: no checker logic is built and resync is ignored. step_err=0, dir_up=1 and err_cnt=0 as constants. Decode and handshake behaviour are identical.

Test Plan:
- Reset then a single word g_in=4'b0110 with out_ready=1 -> next cycle out_valid=1, b_out=4'b0100, step_err=0. Accept g_in=4'b1000 -> b_out=4'b1111.
- Stream Gray 0000,0001,0011,0010 back-to-back with out_ready=1 -> b_out 0,1,2,3 on consecutive cycles, dir_up=1, step_err=0, in_ready never drops.
- Wrap: Gray 1000 (15) then 0000 (0) -> dir_up=1, step_err=0. Then 0000 to 1000 -> b_out=15, dir_up=0.
- Illegal jump: 0011 then 0110 -> second word step_err=1, err_cnt=1. Repeat the jump 300 times -> err_cnt saturates at 255. Pulse resync, then send 1111 -> step_err=0.
- Backpressure: out_valid=1 and out_ready=0 for 5 cycles while g_in toggles -> in_ready=0 and b_out stable. Raise out_ready -> the held word is consumed and the new word is accepted on the same cycle.
- Assert rst asynchronously mid-stream between edges -> out_valid, step_err and err_cnt go to 0 immediately, dir_up=1. The first word after reset gives step_err=0.
